imm_gen_reg: RTL and testbench

//   Registered, parametrised immediate generator for the Decode->Execute boundary.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/imm_gen_reg_if.sv | 23 ++
 rtl/imm_decode.sv | 29 ++
 rtl/imm_gen_reg.sv | 49 ++++
 tb/tb_imm_gen_reg.sv | 119 +++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate format codes and datapath width constants shared by the decode/execute slice
package riscv_pkg;
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_Z     = 3'b101;
    localparam logic [2:0] IMM_SHAMT = 3'b110;
    localparam logic [2:0] IMM_RSVD  = 3'b111;
    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;
endpackage

// File: rtl/imm_gen_reg_if.sv
// imm_gen_reg_if: decode-side request and execute-side registered immediate bundle
interface imm_gen_reg_if #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic [2:0]           imm_src;
    logic [24:0]          instr;
    logic                 out_valid;
    logic [XLEN-1:0]      imm_ext;
    logic                 imm_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    modport master (
        output in_valid, stall, flush, imm_src, instr,
        input  out_valid, imm_ext, imm_err, err_cnt
    );
    modport slave (
        input  in_valid, stall, flush, imm_src, instr,
        output out_valid, imm_ext, imm_err, err_cnt
    );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32I/RV64I immediate decode from instr[31:7], sign/zero-extended to XLEN
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_32
) (
    input  logic [2:0]      imm_src,
    input  logic [24:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic            err
);
    // instr[k] here is instruction bit k+7; every format is built as a signed 32-bit value
    // (zero-extended fields have bit 31 clear) and then sign-extended to XLEN.
    logic signed [31:0] v;
    logic               s;
    assign s = instr[24];
    always_comb begin
        v = imm_src == IMM_I     ? {{20{s}}, instr[24:13]} :
            imm_src == IMM_S     ? {{20{s}}, instr[24:18], instr[4:0]} :
            imm_src == IMM_B     ? {{20{s}}, instr[0], instr[23:18], instr[4:1], 1'b0} :
            imm_src == IMM_J     ? {{12{s}}, instr[12:5], instr[13], instr[23:14], 1'b0} :
            imm_src == IMM_U     ? {instr[24:5], 12'b0} :
            imm_src == IMM_Z     ? {27'b0, instr[12:8]} :
            imm_src == IMM_SHAMT ? (XLEN == XLEN_64 ? {26'b0, instr[18:13]} : {27'b0, instr[17:13]}) :
                                   32'sd0;
        err = imm_src == IMM_RSVD;
    end
    assign imm = XLEN'(v);
endmodule

// File: rtl/imm_gen_reg.sv
// imm_gen_reg: Decode->Execute immediate register with flush/stall priority and saturating reserved-code counter
module imm_gen_reg
    import riscv_pkg::*;
#(
    parameter int XLEN      = XLEN_32,
    parameter int ERR_CNT_W = 8
) (
    input logic          clk,
    input logic          reset,
    imm_gen_reg_if.slave bus
);
    logic [XLEN-1:0]      imm;
    logic                 err;
    logic                 valid_q;
    logic [XLEN-1:0]      imm_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] cnt_q;
    imm_decode #(.XLEN(XLEN)) u_dec (
        .imm_src (bus.imm_src),
        .instr   (bus.instr),
        .imm     (imm),
        .err     (err)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (flush_now()) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
            err_q   <= 1'b0;
        end else if (!bus.stall) begin
            valid_q <= bus.in_valid;
            imm_q   <= imm;
            err_q   <= bus.in_valid & err;
            // Count only valid reserved loads, saturating at all-ones.
            if (bus.in_valid && err && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end
    function automatic logic flush_now();
        return bus.flush;
    endfunction
    assign bus.out_valid = valid_q;
    assign bus.imm_ext   = imm_q;
    assign bus.imm_err   = err_q;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_imm_gen_reg.sv
// tb_imm_gen_reg: randomized and directed check of imm_gen_reg at XLEN=32 and XLEN=64 against an arithmetic model
module tb_imm_gen_reg;
    import riscv_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iv = 1'b0, st = 1'b0, fl = 1'b0;
    logic [2:0]  src = 3'b0;
    logic [24:0] ins = '0;
    int          nvec = 0, nerr = 0;
    bit          mv [2];
    longint      mi [2];
    bit          me [2];
    int          mc [2];
    int          cmax [2] = '{3, 7};
    imm_gen_reg_if #(.XLEN(32), .ERR_CNT_W(2)) b32 ();
    imm_gen_reg_if #(.XLEN(64), .ERR_CNT_W(3)) b64 ();
    assign b32.in_valid = iv;  assign b64.in_valid = iv;
    assign b32.stall    = st;  assign b64.stall    = st;
    assign b32.flush    = fl;  assign b64.flush    = fl;
    assign b32.imm_src  = src; assign b64.imm_src  = src;
    assign b32.instr    = ins; assign b64.instr    = ins;
    imm_gen_reg #(.XLEN(32), .ERR_CNT_W(2)) d32 (.clk(clk), .reset(reset), .bus(b32));
    imm_gen_reg #(.XLEN(64), .ERR_CNT_W(3)) d64 (.clk(clk), .reset(reset), .bus(b64));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Immediate value as a signed integer, from the ISA field layout and two's-complement weights.
    function automatic longint ref_imm(logic [2:0] c, logic [31:0] f, bit x64);
        longint v;
        case (c)
            3'd0: begin v = f[31:20]; if (f[31]) v -= 4096; end
            3'd1: begin v = {f[31:25], f[11:7]}; if (f[31]) v -= 4096; end
            3'd2: begin v = 2 * longint'({f[31], f[7], f[30:25], f[11:8]}); if (f[31]) v -= 8192; end
            3'd3: begin v = 2 * longint'({f[31], f[19:12], f[20], f[30:21]}); if (f[31]) v -= longint'(1) << 21; end
            3'd4: begin v = 4096 * longint'(f[31:12]); if (f[31]) v -= longint'(1) << 32; end
            3'd5: v = f[19:15];
            3'd6: v = x64 ? longint'(f[25:20]) : longint'(f[24:20]);
            default: v = 0;
        endcase
        return v;
    endfunction
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mv[k] = 0; mi[k] = 0; me[k] = 0; mc[k] = 0;
            end else if (fl) begin
                mv[k] = 0; mi[k] = 0; me[k] = 0;
            end else if (!st) begin
                mv[k] = iv;
                mi[k] = ref_imm(src, {ins, 7'b0}, k == 1);
                me[k] = iv && src == 3'd7;
                if (iv && src == 3'd7 && mc[k] < cmax[k]) mc[k]++;
            end
        end
    endtask
    task automatic step(bit r, bit v, bit s, bit f, logic [2:0] c, logic [31:0] w);
        reset = r; iv = v; st = s; fl = f; src = c; ins = w[31:7];
        @(posedge clk);
        model_step();
        #1;
        chk("vld32", {63'b0, b32.out_valid}, {63'b0, mv[0]});
        chk("imm32", {32'b0, b32.imm_ext}, {32'b0, mi[0][31:0]});
        chk("err32", {63'b0, b32.imm_err}, {63'b0, me[0]});
        chk("cnt32", {62'b0, b32.err_cnt}, 64'(mc[0]));
        chk("vld64", {63'b0, b64.out_valid}, {63'b0, mv[1]});
        chk("imm64", b64.imm_ext, mi[1]);
        chk("err64", {63'b0, b64.imm_err}, {63'b0, me[1]});
        chk("cnt64", {61'b0, b64.err_cnt}, 64'(mc[1]));
    endtask
    initial begin
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        step(1, 0, 0, 0, 3'd0, 32'h0);
        step(1, 1, 1, 1, 3'd7, 32'hFFFFFFFF);
        chk("rst_v", {63'b0, b32.out_valid}, 64'd0);
        chk("rst_i", b64.imm_ext, 64'd0);
        chk("rst_c", {62'b0, b32.err_cnt}, 64'd0);
        step(0, 1, 0, 0, IMM_I, 32'hFFF00000);
        chk("i_fff", {32'b0, b32.imm_ext}, 64'h0000_0000_FFFF_FFFF);
        chk("i_vld", {63'b0, b32.out_valid}, 64'd1);
        step(0, 1, 0, 0, IMM_U, 32'h80000000);
        chk("u64", b64.imm_ext, 64'hFFFF_FFFF_8000_0000);
        step(0, 1, 0, 0, IMM_B, 32'hFE000EE3);
        chk("b64", b64.imm_ext, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 1, 0, 0, IMM_J, 32'h00100000);
        chk("j2048", b64.imm_ext, 64'd2048);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'($urandom), 1, 0, 3'($urandom), $urandom);
            chk("stall_hold", {32'b0, b32.imm_ext}, 64'd2048);
        end
        step(0, 1, 1, 1, IMM_I, 32'hFFF00000);
        chk("fl_st_v", {63'b0, b64.out_valid}, 64'd0);
        chk("fl_st_i", b64.imm_ext, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, IMM_RSVD, $urandom);
            chk("rsvd_err", {63'b0, b32.imm_err}, 64'd1);
            chk("rsvd_imm", {32'b0, b32.imm_ext}, 64'd0);
            chk("rsvd_cnt", {62'b0, b32.err_cnt}, 64'(exp_cnt[i]));
        end
        step(0, 0, 0, 0, IMM_RSVD, $urandom);
        chk("rsvd_nv", {62'b0, b32.err_cnt}, 64'd3);
        step(0, 1, 0, 0, IMM_Z, 32'h000F8000);
        chk("z31", b64.imm_ext, 64'd31);
        step(0, 1, 0, 0, IMM_SHAMT, 32'hFFF00000 & 32'h03F00000);
        chk("sh63", b64.imm_ext, 64'd63);
        chk("sh31", {32'b0, b32.imm_ext}, 64'd31);
        step(1, 1, 0, 0, IMM_I, 32'hFFF00000);
        chk("mid_rst", {62'b0, b32.err_cnt}, 64'd0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, 3'($urandom), $urandom);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
